stim_prog_arbiter: RTL and testbench

- Shares the single stim_sequencer programming bus (prog_module/prog_channel/prog_address/prog_word/prog_trig) between N_REQ independent requesters, e.g. frequency config controllers, host bridge, closed-loop updater.
- Each write is issued as the bus's two-cycle protocol: a setup cycle with trig low, then a trig cycle with the same fields.
- Round-robin arbitration, with burst locking so a requester's multi-register sequence is never interleaved with another's.
- Sits between the requesters and main.v's stim_sequencer programming inputs.

---
 rtl/stim_prog_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/stim_prog_arbiter.sv | 93 +++++++++
 tb/tb_stim_prog_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_prog_pkg.sv
// stim_prog_pkg: shared stim_sequencer register map, prog field widths and arbiter FSM encoding
package stim_prog_pkg;
  localparam logic [3:0] ADDR_TRIGGER_CFG = 4'd0;
  localparam logic [3:0] ADDR_SHAPE_CFG = 4'd1;
  localparam logic [3:0] ADDR_START_STIM = 4'd4;
  localparam logic [3:0] ADDR_PHASE2 = 4'd5;
  localparam logic [3:0] ADDR_END_STIM = 4'd7;
  localparam logic [3:0] ADDR_EVENT_END = 4'd13;
  localparam int MOD_W = 5;
  localparam int CH_W = 4;
  localparam int ADDR_W = 4;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {IDLE, SETUP, TRIG} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority picker, searching upward from ptr + 1
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    // Walk from the farthest slot back to the nearest so the nearest valid one wins
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
    gnt = (|req) ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/stim_prog_arbiter.sv
// stim_prog_arbiter: round-robin, burst-locking arbiter onto the stim_sequencer programming bus
module stim_prog_arbiter
  import stim_prog_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int CNT_W = 16,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [MOD_W*N_REQ-1:0]  req_module,
  input  logic [CH_W*N_REQ-1:0]   req_channel,
  input  logic [ADDR_W*N_REQ-1:0] req_address,
  input  logic [WORD_W*N_REQ-1:0] req_word,
  output logic [N_REQ-1:0]        req_ready,
  output logic [MOD_W-1:0]        prog_module,
  output logic [CH_W-1:0]         prog_channel,
  output logic [ADDR_W-1:0]       prog_address,
  output logic [WORD_W-1:0]       prog_word,
  output logic                    prog_trig,
  output logic [IW-1:0]           grant_id,
  output logic                    locked,
  output logic                    busy,
  output logic                    lock_abort,
  output logic [CNT_W-1:0]        write_count
);
  localparam int TW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
  state_t state;
  logic [IW-1:0] ptr, arb_idx, cand;
  logic [N_REQ-1:0] arb_gnt;
  logic [TW-1:0] tcnt;
  logic accept;
  rr_arbiter #(.N(N_REQ)) u_rr (.req(req_valid), .ptr(ptr), .gnt(arb_gnt), .idx(arb_idx));
  // While locked only the owner may be served; everyone else keeps waiting
  assign cand = locked ? grant_id : arb_idx;
  assign req_ready = (!reset && state == IDLE)
                   ? (locked ? (N_REQ'(req_valid[grant_id]) << grant_id) : arb_gnt) : '0;
  assign accept = |req_ready;
  assign busy = (state != IDLE) || locked;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prog_module <= '0;
      prog_channel <= '0;
      prog_address <= '0;
      prog_word <= '0;
      prog_trig <= 1'b0;
      grant_id <= '0;
      ptr <= IW'(N_REQ - 1);
      locked <= 1'b0;
      lock_abort <= 1'b0;
      write_count <= '0;
      tcnt <= '0;
    end else begin
      lock_abort <= 1'b0;
      prog_trig <= state == SETUP;
      case (state)
        IDLE: begin
          if (accept) begin
            prog_module <= req_module[MOD_W*cand +: MOD_W];
            prog_channel <= req_channel[CH_W*cand +: CH_W];
            prog_address <= req_address[ADDR_W*cand +: ADDR_W];
            prog_word <= req_word[WORD_W*cand +: WORD_W];
            grant_id <= cand;
            ptr <= cand;
            locked <= !req_last[cand];
            tcnt <= '0;
            state <= SETUP;
          end else if (locked && LOCK_TIMEOUT != 0) begin
            // Owner went quiet: count idle cycles and break the lock on expiry
            if (tcnt == T_LAST) begin
              locked <= 1'b0;
              lock_abort <= 1'b1;
              tcnt <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        SETUP: state <= TRIG;
        TRIG: begin
          state <= IDLE;
          write_count <= write_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stim_prog_arbiter.sv
// tb_stim_prog_arbiter: randomized queue-driven bench against a transaction-level round-robin model
module tb_stim_prog_arbiter;
  import stim_prog_pkg::*;
  localparam int N = 4;
  localparam int LT = 8;
  localparam int CW = 2;
  typedef struct {
    logic [4:0]  m;
    logic [3:0]  c;
    logic [3:0]  a;
    logic [15:0] w;
    logic        last;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [5*N-1:0] req_module;
  logic [4*N-1:0] req_channel, req_address;
  logic [16*N-1:0] req_word;
  logic [4:0] prog_module;
  logic [3:0] prog_channel, prog_address;
  logic [15:0] prog_word;
  logic prog_trig, locked, busy, lock_abort;
  logic [1:0] grant_id;
  logic [CW-1:0] write_count;
  beat_t q[N][$];
  int checks = 0;
  int errors = 0;

  stim_prog_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_module(req_module), .req_channel(req_channel), .req_address(req_address),
    .req_word(req_word), .req_ready(req_ready), .prog_module(prog_module),
    .prog_channel(prog_channel), .prog_address(prog_address), .prog_word(prog_word),
    .prog_trig(prog_trig), .grant_id(grant_id), .locked(locked), .busy(busy),
    .lock_abort(lock_abort), .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    req_valid = '0;
    req_last = '0;
    req_module = '0;
    req_channel = '0;
    req_address = '0;
    req_word = '0;
  endtask

  task automatic set_req(input int i, input beat_t b);
    req_valid[i] = 1'b1;
    req_last[i] = b.last;
    req_module[5*i +: 5] = b.m;
    req_channel[4*i +: 4] = b.c;
    req_address[4*i +: 4] = b.a;
    req_word[16*i +: 16] = b.w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic beat_t rnd_beat(input logic last);
    beat_t b;
    b.m = 5'($urandom);
    b.c = 4'($urandom);
    b.a = 4'($urandom);
    b.w = 16'($urandom);
    b.last = last;
    return b;
  endfunction

  // Drains q[] with every non-empty requester always valid; the expected write order
  // is derived from whole bursts served in rotation starting after requester N-1.
  task automatic run_queues(input string name);
    beat_t m[N][$];
    beat_t exp[$];
    int exp_id[$];
    beat_t b;
    beat_t e;
    int p, r, n, last_t, cyc, budget;
    logic done;
    logic [CW-1:0] wc0;
    wc0 = write_count;
    for (int i = 0; i < N; i++) m[i] = q[i];
    p = N - 1;
    forever begin
      r = -1;
      for (int k = 1; k <= N; k++) if (r < 0 && m[(p + k) % N].size() > 0) r = (p + k) % N;
      if (r < 0) break;
      done = 1'b0;
      while (!done && m[r].size() > 0) begin
        b = m[r].pop_front();
        exp.push_back(b);
        exp_id.push_back(r);
        done = b.last;
      end
      p = r;
    end
    n = 0;
    last_t = -1;
    cyc = 0;
    budget = 3 * exp.size() + 20;
    while (n < exp.size() && cyc < budget) begin
      drive_idle();
      for (int i = 0; i < N; i++) if (q[i].size() > 0) set_req(i, q[i][0]);
      @(negedge clk);
      checks++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        errors++;
        $display("FAIL %s ready cyc%0d got %b valid %b", name, cyc, req_ready, req_valid);
      end
      if (prog_trig) begin
        e = exp[n];
        checks++;
        if (grant_id !== 2'(exp_id[n])) begin
          errors++;
          $display("FAIL %s grant w%0d got %0d want %0d", name, n, grant_id, exp_id[n]);
        end
        checks++;
        if ({prog_module, prog_channel, prog_address, prog_word} !== {e.m, e.c, e.a, e.w}) begin
          errors++;
          $display("FAIL %s fields w%0d got %h want %h", name, n,
                   {prog_module, prog_channel, prog_address, prog_word}, {e.m, e.c, e.a, e.w});
        end
        checks++;
        if (locked !== !e.last) begin
          errors++;
          $display("FAIL %s locked w%0d got %b want %b", name, n, locked, !e.last);
        end
        if (last_t >= 0) begin
          checks++;
          if (cyc - last_t != 3) begin
            errors++;
            $display("FAIL %s spacing w%0d got %0d want 3", name, n, cyc - last_t);
          end
        end
        last_t = cyc;
        n++;
      end
      for (int i = 0; i < N; i++) if (req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
      step();
      cyc++;
    end
    drive_idle();
    checks++;
    if (n != exp.size()) begin
      errors++;
      $display("FAIL %s writes got %0d want %0d", name, n, exp.size());
    end
    checks++;
    if (write_count !== CW'(int'(wc0) + n)) begin
      errors++;
      $display("FAIL %s write_count got %0d want %0d", name, write_count, CW'(int'(wc0) + n));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    req_valid = '1;
    step();
    @(negedge clk);
    checks++;
    if ({req_ready, prog_module, prog_channel, prog_address, prog_word, prog_trig, grant_id,
         locked, busy, lock_abort, write_count} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %h want 0", {req_ready, prog_module, prog_channel,
               prog_address, prog_word, prog_trig, grant_id, locked, busy, lock_abort, write_count});
    end
    drive_idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    beat_t b;
    do_reset();
    b.m = 5'd3; b.c = 4'd5; b.a = ADDR_EVENT_END; b.w = 16'd999; b.last = 1'b1;
    set_req(2, b);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || prog_trig !== 1'b0) begin
      errors++;
      $display("FAIL single c0 ready %b trig %b want 0100 0", req_ready, prog_trig);
    end
    step();
    drive_idle();
    @(negedge clk);
    checks++;
    if ({prog_module, prog_channel, prog_address, prog_word, prog_trig, locked} !==
        {5'd3, 4'd5, 4'd13, 16'd999, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single c1 got %h want setup with 3/5/13/999", {prog_module, prog_channel,
               prog_address, prog_word, prog_trig, locked});
    end
    step();
    @(negedge clk);
    checks++;
    if ({prog_module, prog_channel, prog_address, prog_word, prog_trig, locked} !==
        {5'd3, 4'd5, 4'd13, 16'd999, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single c2 got %h want trig with 3/5/13/999", {prog_module, prog_channel,
               prog_address, prog_word, prog_trig, locked});
    end
    step();
    @(negedge clk);
    checks++;
    if ({prog_word, prog_trig, write_count, grant_id, locked, busy} !==
        {16'd999, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single c3 word %0d trig %b count %0d grant %0d locked %b busy %b",
               prog_word, prog_trig, write_count, grant_id, locked, busy);
    end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) repeat (2) q[i].push_back(rnd_beat(1'b1));
    run_queues("round_robin");
  endtask

  task automatic test_burst();
    do_reset();
    repeat (2) q[0].push_back(rnd_beat(1'b1));
    for (int k = 0; k < 6; k++) q[1].push_back(rnd_beat(k == 5));
    q[3].push_back(rnd_beat(1'b1));
    run_queues("burst");
  endtask

  task automatic test_random();
    int nb, len;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        nb = $urandom_range(0, 3);
        for (int k = 0; k < nb; k++) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) q[i].push_back(rnd_beat(j == len - 1));
        end
      end
      run_queues("random");
    end
  endtask

  task automatic test_timeout();
    beat_t b0, b1;
    do_reset();
    b0 = rnd_beat(1'b0);
    b1 = rnd_beat(1'b1);
    set_req(0, b0);
    set_req(1, b1);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL timeout accept ready got %b want 0001", req_ready);
    end
    step();
    req_valid[0] = 1'b0;
    for (int c = 1; c <= LT + 2; c++) begin
      @(negedge clk);
      checks++;
      if (lock_abort !== 1'b0 || req_ready !== 4'b0000 || locked !== 1'b1) begin
        errors++;
        $display("FAIL timeout hold c%0d abort %b ready %b locked %b want 0 0000 1",
                 c, lock_abort, req_ready, locked);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (lock_abort !== 1'b1 || locked !== 1'b0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL timeout abort abort %b locked %b ready %b want 1 0 0010",
               lock_abort, locked, req_ready);
    end
    step();
    drive_idle();
    @(negedge clk);
    checks++;
    if (lock_abort !== 1'b0) begin
      errors++;
      $display("FAIL timeout pulse abort got %b want 0", lock_abort);
    end
    step();
    @(negedge clk);
    checks++;
    if (prog_trig !== 1'b1 || grant_id !== 2'd1 || prog_word !== b1.w) begin
      errors++;
      $display("FAIL timeout req1 trig %b grant %0d word %h want 1 1 %h",
               prog_trig, grant_id, prog_word, b1.w);
    end
    step();
  endtask

  task automatic test_reset_in_trig();
    do_reset();
    set_req(0, rnd_beat(1'b1));
    step();
    drive_idle();
    step();
    @(negedge clk);
    checks++;
    if (prog_trig !== 1'b1) begin
      errors++;
      $display("FAIL rst_trig pre trig got %b want 1", prog_trig);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, prog_module, prog_channel, prog_address, prog_word, prog_trig, grant_id,
         locked, busy, lock_abort, write_count} !== '0) begin
      errors++;
      $display("FAIL rst_trig outputs got %h want 0", {req_ready, prog_module, prog_channel,
               prog_address, prog_word, prog_trig, grant_id, locked, busy, lock_abort, write_count});
    end
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      checks++;
      if (prog_trig !== 1'b0 || busy !== 1'b0 || write_count !== 2'd0) begin
        errors++;
        $display("FAIL rst_trig after c%0d trig %b busy %b count %0d want 0 0 0",
                 c, prog_trig, busy, write_count);
      end
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 5; k++) q[k % N].push_back(rnd_beat(1'b1));
    run_queues("wrap");
    checks++;
    if (write_count !== 2'd1) begin
      errors++;
      $display("FAIL wrap count got %0d want 1", write_count);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_random();
    test_timeout();
    test_reset_in_trig();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
